// File: rtl/mips_ctrl_pkg.sv
// Shared opcodes, funct codes, ALU encodings and the
// pipelined control bundle for the MIPS pipeline controller.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef struct packed {
    logic       valid;
    logic       regwrite;
    logic       memtoreg;
    logic       memwrite;
    logic       alusrc;
    logic       regdst;
    logic [2:0] alucontrol;
  } ctrl_t;

  function automatic logic rFunctOk(
    input logic [5:0] funct
  );
    return funct == FN_ADD || funct == FN_SUB ||
           funct == FN_AND || funct == FN_OR  ||
           funct == FN_SLT;
  endfunction

  function automatic logic [2:0] aluOfFunct(
    input logic [5:0] funct
  );
    logic [2:0] alu;
    alu = ALU_ADD;
    unique case (1'b1)
      (funct == FN_SUB): alu = ALU_SUB;
      (funct == FN_AND): alu = ALU_AND;
      (funct == FN_OR):  alu = ALU_OR;
      (funct == FN_SLT): alu = ALU_SLT;
      default:           alu = ALU_ADD;
    endcase
    return alu;
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// D-stage main + ALU decoder, purely combinational.
// PIPE_CTRL_JUMP_EN enables decoding of j (op 000010).
module ctrl_decode
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output ctrl_t      ctrl,
  output logic       branch,
  output logic       jump,
  output logic       invalid
);

  always_comb begin
    ctrl   = '0;
    branch = 1'b0;
    jump   = 1'b0;
    unique case (1'b1)
      (op == OP_RTYPE && rFunctOk(funct)): begin
        ctrl.valid      = 1'b1;
        ctrl.regwrite   = 1'b1;
        ctrl.regdst     = 1'b1;
        ctrl.alucontrol = aluOfFunct(funct);
      end
      (op == OP_LW): begin
        ctrl.valid      = 1'b1;
        ctrl.regwrite   = 1'b1;
        ctrl.memtoreg   = 1'b1;
        ctrl.alusrc     = 1'b1;
        ctrl.alucontrol = ALU_ADD;
      end
      (op == OP_SW): begin
        ctrl.valid      = 1'b1;
        ctrl.memwrite   = 1'b1;
        ctrl.alusrc     = 1'b1;
        ctrl.alucontrol = ALU_ADD;
      end
      (op == OP_BEQ): begin
        ctrl.valid      = 1'b1;
        ctrl.alucontrol = ALU_SUB;
        branch          = 1'b1;
      end
      (op == OP_ADDI): begin
        ctrl.valid      = 1'b1;
        ctrl.regwrite   = 1'b1;
        ctrl.alusrc     = 1'b1;
        ctrl.alucontrol = ALU_ADD;
      end
`ifdef PIPE_CTRL_JUMP_EN
      (op == OP_J): begin
        ctrl.valid = 1'b1;
        jump       = 1'b1;
      end
`endif
      default: ctrl = '0;
    endcase
    invalid = ~ctrl.valid;
  end

endmodule

// File: rtl/pipe_controller.sv
// MIPS 5-stage control: D decode, E/M/W control registers, retire count.
// Optional j decode under PIPE_CTRL_JUMP_EN.
module pipe_controller
  import mips_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opD,
  input  logic [5:0]       functD,
  input  logic             flushE,
  output logic             branchD,
  output logic             jumpD,
  output logic             invalidD,
  output logic             regwriteE,
  output logic             memtoregE,
  output logic             memwriteE,
  output logic             alusrcE,
  output logic             regdstE,
  output logic [2:0]       alucontrolE,
  output logic             regwriteM,
  output logic             memtoregM,
  output logic             memwriteM,
  output logic             regwriteW,
  output logic             memtoregW,
  output logic [CNT_W-1:0] retiredW
);

  ctrl_t ctrlD;
  ctrl_t ctrlE;
  ctrl_t ctrlM;
  ctrl_t ctrlW;

  ctrl_decode uDecode (
    .op      (opD),
    .funct   (functD),
    .ctrl    (ctrlD),
    .branch  (branchD),
    .jump    (jumpD),
    .invalid (invalidD)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrlE <= '0;
    end else if (flushE) begin
      ctrlE <= '0;
    end else begin
      ctrlE <= ctrlD;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrlM <= '0;
      ctrlW <= '0;
    end else begin
      ctrlM <= ctrlE;
      ctrlW <= ctrlM;
    end
  end

  // Counted as the instruction lands in W, so the count
  // moves on the same edge as the W-stage controls.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      retiredW <= '0;
    end else if (ctrlM.valid) begin
      retiredW <= retiredW + CNT_W'(1);
    end
  end

  assign regwriteE   = ctrlE.regwrite;
  assign memtoregE   = ctrlE.memtoreg;
  assign memwriteE   = ctrlE.memwrite;
  assign alusrcE     = ctrlE.alusrc;
  assign regdstE     = ctrlE.regdst;
  assign alucontrolE = ctrlE.alucontrol;
  assign regwriteM   = ctrlM.regwrite;
  assign memtoregM   = ctrlM.memtoreg;
  assign memwriteM   = ctrlM.memwrite;
  assign regwriteW   = ctrlW.regwrite;
  assign memtoregW   = ctrlW.memtoreg;

endmodule

// File: tb/tb_pipe_controller.sv
// Randomized bench for pipe_controller against a queue-based
// model of issued instructions; CNT_W=4 to exercise wrap.
module tb_pipe_controller;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [5:0]    opD;
  logic [5:0]    functD;
  logic          flushE;
  logic          branchD;
  logic          jumpD;
  logic          invalidD;
  logic          regwriteE;
  logic          memtoregE;
  logic          memwriteE;
  logic          alusrcE;
  logic          regdstE;
  logic [2:0]    alucontrolE;
  logic          regwriteM;
  logic          memtoregM;
  logic          memwriteM;
  logic          regwriteW;
  logic          memtoregW;
  logic [CW-1:0] retiredW;

  int nCmp = 0;
  int nErr = 0;

  // {valid,regwrite,memtoreg,memwrite,alusrc,regdst,alu[2:0]}
  typedef struct packed {
    logic       br;
    logic       jp;
    logic       inv;
    logic [8:0] c;
  } dec_t;

  logic [8:0] issued[$];

  pipe_controller #(.CNT_W(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .opD         (opD),
    .functD      (functD),
    .flushE      (flushE),
    .branchD     (branchD),
    .jumpD       (jumpD),
    .invalidD    (invalidD),
    .regwriteE   (regwriteE),
    .memtoregE   (memtoregE),
    .memwriteE   (memwriteE),
    .alusrcE     (alusrcE),
    .regdstE     (regdstE),
    .alucontrolE (alucontrolE),
    .regwriteM   (regwriteM),
    .memtoregM   (memtoregM),
    .memwriteM   (memwriteM),
    .regwriteW   (regwriteW),
    .memtoregW   (memtoregW),
    .retiredW    (retiredW)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    nCmp++;
    if (got !== exp) begin
      nErr++;
      $display("FAIL %s: got %0h want %0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic dec_t mdlDec(
    input logic [5:0] op,
    input logic [5:0] fn
  );
    dec_t r;
    r = '0;
    case (op)
      6'b000000:
        case (fn)
          6'b100000: r.c = 9'b1_1_0_0_0_1_010;
          6'b100010: r.c = 9'b1_1_0_0_0_1_110;
          6'b100100: r.c = 9'b1_1_0_0_0_1_000;
          6'b100101: r.c = 9'b1_1_0_0_0_1_001;
          6'b101010: r.c = 9'b1_1_0_0_0_1_111;
          default:   r.c = '0;
        endcase
      6'b100011: r.c = 9'b1_1_1_0_1_0_010;
      6'b101011: r.c = 9'b1_0_0_1_1_0_010;
      6'b000100: begin
        r.c  = 9'b1_0_0_0_0_0_110;
        r.br = 1'b1;
      end
      6'b001000: r.c = 9'b1_1_0_0_1_0_010;
`ifdef PIPE_CTRL_JUMP_EN
      6'b000010: begin
        r.c  = 9'b1_0_0_0_0_0_000;
        r.jp = 1'b1;
      end
`endif
      default: r.c = '0;
    endcase
    r.inv = ~r.c[8];
    return r;
  endfunction

  function automatic logic [8:0] slot(input int i);
    return (i < issued.size()) ? issued[i] : 9'd0;
  endfunction

  task automatic chkPipe();
    logic [8:0] e;
    logic [8:0] m;
    logic [8:0] w;
    int n;
    e = slot(0);
    m = slot(1);
    w = slot(2);
    n = 0;
    for (int i = 2; i < issued.size(); i++) n += issued[i][8];
    chk("ctlE", {regwriteE, memtoregE, memwriteE,
                 alusrcE, regdstE, alucontrolE}, e[7:0]);
    chk("ctlM", {regwriteM, memtoregM, memwriteM}, m[7:5]);
    chk("ctlW", {regwriteW, memtoregW}, w[7:6]);
    chk("retW", retiredW, n % (1 << CW));
  endtask

  task automatic step(
    input logic [5:0] op,
    input logic [5:0] fn,
    input logic       fl
  );
    dec_t d;
    opD    = op;
    functD = fn;
    flushE = fl;
    #1;
    d = mdlDec(op, fn);
    chk("decD", {branchD, jumpD, invalidD}, {d.br, d.jp, d.inv});
    @(posedge clk);
    issued.push_front(fl ? 9'd0 : d.c);
    #1;
    chkPipe();
  endtask

  task automatic midReset();
    #2;
    rst = 1'b0;
    issued.delete();
    #1;
    chkPipe();
    chk("rstCnt", retiredW, 0);
    #3;
    rst = 1'b1;
  endtask

  logic [5:0] rFn[5];
  logic [2:0] rAlu[5];

  initial begin
    rFn  = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    rAlu = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};

    rst    = 1'b0;
    opD    = 6'b100011;
    functD = 6'd0;
    flushE = 1'b0;
    #12;
    chkPipe();
    chk("rstDec", invalidD, 0);
    rst = 1'b1;

    step(6'b100011, 6'd0, 1'b0);
    step(6'b111111, 6'd0, 1'b0);
    step(6'b111111, 6'd0, 1'b0);
    chk("lwW", {regwriteW, memtoregW}, 2'b11);
    chk("lwRet", retiredW, 1);

    for (int i = 0; i < 5; i++) begin
      step(6'b000000, rFn[i], 1'b0);
      chk("rAlu", alucontrolE, rAlu[i]);
      chk("rDst", regdstE, 1);
    end

    step(6'b101011, 6'd0, 1'b0);
    chk("swE", memwriteE, 1);
    step(6'b111111, 6'd0, 1'b0);
    chk("swM", memwriteM, 1);
    step(6'b111111, 6'd0, 1'b0);
    chk("swW", regwriteW, 0);

    step(6'b100011, 6'd0, 1'b1);
    chk("flE", {regwriteE, memtoregE}, 2'b00);

    opD = 6'b000100;
    functD = 6'd0;
    #1;
    chk("beqD", branchD, 1);
    step(6'b000100, 6'd0, 1'b0);

    opD = 6'b111111;
    #1;
    chk("badD", invalidD, 1);
    step(6'b111111, 6'd0, 1'b0);

    opD = 6'b000010;
    #1;
`ifdef PIPE_CTRL_JUMP_EN
    chk("jD", {jumpD, invalidD}, 2'b10);
`else
    chk("jD", {jumpD, invalidD}, 2'b01);
`endif
    step(6'b000010, 6'd0, 1'b0);
    step(6'b000000, 6'd0, 1'b0);
    step(6'b000000, 6'd0, 1'b0);

    for (int k = 0; k < 200; k++) begin
      int sel;
      logic [5:0] op;
      logic [5:0] fn;
      sel = $urandom_range(0, 11);
      op  = 6'b000000;
      fn  = 6'($urandom);
      case (sel)
        0, 1, 2, 3, 4: fn = rFn[sel];
        5:  op = 6'b100011;
        6:  op = 6'b101011;
        7:  op = 6'b000100;
        8:  op = 6'b001000;
        9:  op = 6'b000010;
        10: op = 6'($urandom);
        default: op = 6'b000000;
      endcase
      step(op, fn, $urandom_range(0, 4) == 0);
    end

    midReset();
    for (int k = 0; k < 17; k++) step(6'b001000, 6'd0, 1'b0);
    step(6'b111111, 6'd0, 1'b0);
    step(6'b111111, 6'd0, 1'b0);
    chk("wrap", retiredW, 1);

    step(6'b100011, 6'd0, 1'b0);
    step(6'b100011, 6'd0, 1'b0);
    midReset();
    step(6'b111111, 6'd0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             nCmp, nErr);
    $finish;
  end

endmodule
